quant_param_sched: RTL and testbench

- Schedules per-output-tile quantization parameters (bias offset, shift, multiplier, activation select, output zero point) into the post-GEMM quantization datapath.
- Collects SZI packed parameter words per tile into a shadow bank.
- Swaps the shadow bank into the active bank on the first data beat of each new output tile (new_tile_k & last_tile_k).
- Stalls data when the next tile's parameters are not yet complete. Replaces free-running enable pulses with an explicit handshake.

---
 rtl/quant_param_sched_pkg.sv | 16 +
 rtl/quant_param_sched_bank.sv | 52 +++++
 rtl/quant_param_sched.sv | 142 ++++++++++++++
 tb/tb_quant_param_sched.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quant_param_sched_pkg.sv
// Shared types and constants for the quantization parameter scheduler.
// Parameter word type, fill FSM states and per-tile word count.
package quant_param_sched_pkg;

    localparam int QPARAM_SZI = 8;
    localparam int QPARAM_PW = 64;
    localparam int QPARAM_WORDS_PER_TILE = QPARAM_SZI;

    typedef logic [QPARAM_PW-1:0] QParamWord;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } QParamFillState;

endpackage

// File: rtl/quant_param_sched_bank.sv
// Shadow/active parameter bank (qparam bank) for quant_param_sched.
// Indexed shadow write; whole-bank copy to active on swap.
module quant_param_sched_bank #(
    parameter int SZI = 8,
    parameter int PW = 64,
    parameter int IDX_W = $clog2(SZI)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [PW-1:0]    wr_word,
    input  logic             swap_en,
    output logic [SZI*PW-1:0] active_vec
);

    logic [PW-1:0] shadow_q [SZI];
    logic [PW-1:0] shadow_d [SZI];
    logic [PW-1:0] active_q [SZI];
    logic [PW-1:0] active_d [SZI];

    // Next bank contents: one shadow lane write, or full copy on swap
    always_comb begin
        for (int i = 0; i < SZI; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = swap_en ? shadow_q[i] : active_q[i];
        end
        if (wr_en) begin
            shadow_d[wr_idx] = wr_word;
        end
    end

    // Bank storage, cleared on reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SZI; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SZI; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    for (genvar g = 0; g < SZI; g++) begin : g_flat
        assign active_vec[g*PW +: PW] = active_q[g];
    end

endmodule

// File: rtl/quant_param_sched.sv
// Per-tile quantization parameter scheduler with valid/ready handshakes.
// Optional QPARAM_SCHED_STATS_EN adds stall/swap counters.
module quant_param_sched
    import quant_param_sched_pkg::*;
#(
    parameter int SZI = QPARAM_WORDS_PER_TILE,
    parameter int PW = QPARAM_PW,
    parameter int IDX_W = $clog2(SZI)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              p_valid,
    output logic              p_ready,
    input  logic [PW-1:0]     p_word,
    input  logic              d_valid,
    input  logic              d_new_tile_k,
    input  logic              d_last_tile_k,
    output logic              d_ready,
    output logic [SZI*PW-1:0] active_vec,
    output logic              active_valid,
    output logic              swap,
`ifdef QPARAM_SCHED_STATS_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       tiles_swapped,
`endif
    output logic              shadow_full
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SZI - 1);

    QParamFillState state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic active_valid_q, active_valid_d;
    logic swap_q, swap_d;
    logic bnd;
    logic p_acc;
    logic do_swap;

    assign bnd = d_valid & d_new_tile_k & d_last_tile_k;

    // Fill FSM state, index and status registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= FILL;
            idx_q          <= '0;
            active_valid_q <= 1'b0;
            swap_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            active_valid_q <= active_valid_d;
            swap_q         <= swap_d;
        end
    end

    // Next state: fill lanes in order, hold when full until a swap
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        active_valid_d = active_valid_q | do_swap;
        swap_d         = do_swap;
        unique case (state_q)
            FILL: begin
                if (p_acc) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = FULL;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (do_swap) begin
                    state_d = FILL;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
            end
        endcase
    end

    // Handshake outputs; only output-producing tile starts may stall
    always_comb begin
        p_ready      = (state_q == FILL);
        shadow_full  = (state_q == FULL);
        d_ready      = !bnd | shadow_full;
        p_acc        = p_valid & p_ready;
        do_swap      = bnd & d_ready;
        active_valid = active_valid_q;
        swap         = swap_q;
    end

    quant_param_sched_bank #(
        .SZI   (SZI),
        .PW    (PW),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk        (clk),
        .resetn     (resetn),
        .wr_en      (p_acc),
        .wr_idx     (idx_q),
        .wr_word    (p_word),
        .swap_en    (do_swap),
        .active_vec (active_vec)
    );

`ifdef QPARAM_SCHED_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] tiles_swapped_q, tiles_swapped_d;

    // Saturating event counters
    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        tiles_swapped_d = tiles_swapped_q;
        if (bnd && !d_ready && stall_cycles_q != '1) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (do_swap && tiles_swapped_q != '1) begin
            tiles_swapped_d = tiles_swapped_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles_q  <= '0;
            tiles_swapped_q <= '0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            tiles_swapped_q <= tiles_swapped_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign tiles_swapped = tiles_swapped_q;
`endif

endmodule

// File: tb/tb_quant_param_sched.sv
// Testbench for quant_param_sched against a per-tile behavioural model.
// Optional QPARAM_SCHED_STATS_EN also checks the counters.
module tb_quant_param_sched;

    localparam int SZI = 8;
    localparam int PW = 64;

    logic clk = 1'b0;
    logic resetn;
    logic p_valid;
    logic p_ready;
    logic [PW-1:0] p_word;
    logic d_valid;
    logic d_new_tile_k;
    logic d_last_tile_k;
    logic d_ready;
    logic [SZI*PW-1:0] active_vec;
    logic active_valid;
    logic swap;
    logic shadow_full;
`ifdef QPARAM_SCHED_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] tiles_swapped;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    quant_param_sched dut (
        .clk           (clk),
        .resetn        (resetn),
        .p_valid       (p_valid),
        .p_ready       (p_ready),
        .p_word        (p_word),
        .d_valid       (d_valid),
        .d_new_tile_k  (d_new_tile_k),
        .d_last_tile_k (d_last_tile_k),
        .d_ready       (d_ready),
        .active_vec    (active_vec),
        .active_valid  (active_valid),
        .swap          (swap),
`ifdef QPARAM_SCHED_STATS_EN
        .stall_cycles  (stall_cycles),
        .tiles_swapped (tiles_swapped),
`endif
        .shadow_full   (shadow_full)
    );

    // Behavioural model: a tile's words collected so far, plus the live bank
    logic [PW-1:0] m_sh [SZI];
    logic [PW-1:0] m_act [SZI];
    int m_cnt;
    bit m_av;
    bit m_swap;
    longint m_stall;
    longint m_tiles;

    function automatic logic [SZI*PW-1:0] m_vec();
        logic [SZI*PW-1:0] v;
        for (int i = 0; i < SZI; i++) v[i*PW +: PW] = m_act[i];
        return v;
    endfunction

    function automatic bit m_bnd();
        return d_valid && d_new_tile_k && d_last_tile_k;
    endfunction

    function automatic bit exp_dr();
        return !m_bnd() || (m_cnt == SZI);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SZI; i++) begin
            m_sh[i] = '0;
            m_act[i] = '0;
        end
        m_cnt = 0;
        m_av = 0;
        m_swap = 0;
        m_stall = 0;
        m_tiles = 0;
    endtask

    task automatic model_tick();
        bit b;
        bit full;
        b = m_bnd();
        full = (m_cnt == SZI);
        m_swap = 0;
        if (b && !full && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (b && full) begin
            for (int i = 0; i < SZI; i++) m_act[i] = m_sh[i];
            m_av = 1;
            m_cnt = 0;
            m_swap = 1;
            if (m_tiles < 64'hFFFF_FFFF) m_tiles++;
        end else if (p_valid && !full) begin
            m_sh[m_cnt] = p_word;
            m_cnt++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        p_valid = 0;
        p_word = '0;
        d_valid = 0;
        d_new_tile_k = 0;
        d_last_tile_k = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (active_vec !== '0) begin
            n_bad++;
            $display("FAIL reset_vec got %h want 0", active_vec);
        end
        n_cmp++;
        if ({active_valid, swap, shadow_full} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 000",
                     {active_valid, swap, shadow_full});
        end
        resetn = 1;
        #1;
        n_cmp++;
        if (p_ready !== 1'b1 || d_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got p%b d%b want p1 d1",
                     p_ready, d_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_fill_swap();
        for (int i = 0; i < SZI; i++) begin
            p_valid = 1;
            p_word = 64'h11 + 64'(i);
            #1;
            n_cmp++;
            if (p_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL fill_pready[%0d] got %b want 1", i, p_ready);
            end
            cyc();
        end
        p_word = 64'h99;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++;
            if ({p_ready, shadow_full, active_valid} !== 3'b010) begin
                n_bad++;
                $display("FAIL full_flags got %b want 010",
                         {p_ready, shadow_full, active_valid});
            end
            cyc();
        end
        p_valid = 0;
        d_valid = 1;
        d_new_tile_k = 1;
        d_last_tile_k = 1;
        #1;
        n_cmp++;
        if (d_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bnd_ready got %b want 1", d_ready);
        end
        cyc();
        idle_inputs();
        #1;
        n_cmp++;
        if (swap !== 1'b1 || active_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL swap_pulse got s%b v%b want s1 v1",
                     swap, active_valid);
        end
        n_cmp++;
        if (active_vec[0 +: PW] !== 64'h11 ||
            active_vec[7*PW +: PW] !== 64'h18) begin
            n_bad++;
            $display("FAIL swap_lanes got l0 %h l7 %h want 11 18",
                     active_vec[0 +: PW], active_vec[7*PW +: PW]);
        end
        n_cmp++;
        if (active_vec !== m_vec() || p_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL swap_vec got %h want %h", active_vec, m_vec());
        end
        cyc();
        #1;
        n_cmp++;
        if (swap !== 1'b0) begin
            n_bad++;
            $display("FAIL swap_once got %b want 0", swap);
        end
    endtask

    task automatic test_partial();
        logic [SZI*PW-1:0] held;
        held = m_vec();
        for (int i = 0; i < 6; i++) begin
            p_valid = 1;
            p_word = {$urandom, $urandom};
            d_valid = 1;
            d_new_tile_k = 1'($urandom);
            d_last_tile_k = 0;
            #1;
            n_cmp++;
            if (d_ready !== 1'b1 || swap !== 1'b0 ||
                active_vec !== held) begin
                n_bad++;
                $display("FAIL partial[%0d] got d%b s%b vec %h want d1 s0 %h",
                         i, d_ready, swap, active_vec, held);
            end
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        int n_st;
        int k8;
        int t;
        bit done;
        while (m_cnt != 0 && m_cnt != SZI) begin
            p_valid = 1;
            p_word = {$urandom, $urandom};
            cyc();
        end
        if (m_cnt == SZI) begin
            idle_inputs();
            d_valid = 1;
            d_new_tile_k = 1;
            d_last_tile_k = 1;
            cyc();
        end
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            p_valid = 1;
            p_word = {$urandom, $urandom};
            cyc();
        end
        idle_inputs();
        d_valid = 1;
        d_new_tile_k = 1;
        d_last_tile_k = 1;
        n_st = 0;
        k8 = -1;
        done = 0;
        for (t = 0; t < 60 && !done; t++) begin
            p_valid = 1'($urandom_range(0, 1));
            p_word = {$urandom, $urandom};
            #1;
            n_cmp++;
            if (d_ready !== exp_dr()) begin
                n_bad++;
                $display("FAIL stall_dready[%0d] got %b want %b",
                         t, d_ready, exp_dr());
            end
            if (!d_ready) n_st++;
            cyc();
            if (k8 < 0 && m_cnt == SZI) k8 = t;
            done = m_swap;
        end
        idle_inputs();
        n_cmp++;
        if (!done || n_st != k8 + 1) begin
            n_bad++;
            $display("FAIL stall_len got %0d want %0d (done %0d)",
                     n_st, k8 + 1, done);
        end
        #1;
        n_cmp++;
        if (swap !== 1'b1 || active_vec !== m_vec()) begin
            n_bad++;
            $display("FAIL stall_swap got s%b %h want s1 %h",
                     swap, active_vec, m_vec());
        end
        cyc();
        #1;
        n_cmp++;
        if (swap !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_once got %b want 0", swap);
        end
    endtask

    task automatic test_simul();
        logic [PW-1:0] w8;
        for (int i = 0; i < SZI - 1; i++) begin
            p_valid = 1;
            p_word = {$urandom, $urandom};
            cyc();
        end
        w8 = {$urandom, $urandom};
        p_word = w8;
        d_valid = 1;
        d_new_tile_k = 1;
        d_last_tile_k = 1;
        #1;
        n_cmp++;
        if (d_ready !== 1'b0 || p_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_t got d%b p%b want d0 p1", d_ready, p_ready);
        end
        cyc();
        p_valid = 0;
        #1;
        n_cmp++;
        if (d_ready !== 1'b1 || shadow_full !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_t1 got d%b f%b want d1 f1",
                     d_ready, shadow_full);
        end
        cyc();
        idle_inputs();
        #1;
        n_cmp++;
        if (swap !== 1'b1 || active_vec[7*PW +: PW] !== w8) begin
            n_bad++;
            $display("FAIL simul_swap got s%b l7 %h want s1 %h",
                     swap, active_vec[7*PW +: PW], w8);
        end
        cyc();
    endtask

    task automatic test_random();
        bit hold;
        hold = 0;
        for (int t = 0; t < 400; t++) begin
            p_valid = 1'($urandom_range(0, 1));
            p_word = {$urandom, $urandom};
            if (!hold) begin
                d_valid = 1'($urandom_range(0, 1));
                d_new_tile_k = ($urandom_range(0, 3) == 0);
                d_last_tile_k = 1'($urandom_range(0, 1));
            end
            #1;
            n_cmp++;
            if (p_ready !== (m_cnt < SZI) || d_ready !== exp_dr() ||
                shadow_full !== (m_cnt == SZI)) begin
                n_bad++;
                $display("FAIL rnd_hs[%0d] got p%b d%b f%b want p%b d%b f%b",
                         t, p_ready, d_ready, shadow_full,
                         m_cnt < SZI, exp_dr(), m_cnt == SZI);
            end
            n_cmp++;
            if (swap !== m_swap || active_valid !== m_av ||
                active_vec !== m_vec()) begin
                n_bad++;
                $display("FAIL rnd_bank[%0d] got s%b v%b %h want s%b v%b %h",
                         t, swap, active_valid, active_vec,
                         m_swap, m_av, m_vec());
            end
`ifdef QPARAM_SCHED_STATS_EN
            n_cmp++;
            if (stall_cycles !== 32'(m_stall) ||
                tiles_swapped !== 32'(m_tiles)) begin
                n_bad++;
                $display("FAIL rnd_stats[%0d] got %0d %0d want %0d %0d",
                         t, stall_cycles, tiles_swapped, m_stall, m_tiles);
            end
`endif
            hold = m_bnd() && !exp_dr();
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        logic [PW-1:0] fresh [SZI];
        logic [SZI*PW-1:0] want;
        int guard;
        guard = 0;
        while (!(m_cnt == 3 && m_av) && guard < 40) begin
            idle_inputs();
            if (m_cnt == SZI) begin
                d_valid = 1;
                d_new_tile_k = 1;
                d_last_tile_k = 1;
            end else begin
                p_valid = 1;
                p_word = {$urandom, $urandom};
            end
            cyc();
            guard++;
        end
        idle_inputs();
        n_cmp++;
        if (guard >= 40) begin
            n_bad++;
            $display("FAIL arst_setup got cnt %0d want 3", m_cnt);
        end
        #2;
        resetn = 0;
        #1;
        model_reset();
        n_cmp++;
        if (active_vec !== '0 ||
            {active_valid, swap, shadow_full} !== 3'b000) begin
            n_bad++;
            $display("FAIL arst_now got v%b s%b f%b vec %h want all 0",
                     active_valid, swap, shadow_full, active_vec);
        end
`ifdef QPARAM_SCHED_STATS_EN
        n_cmp++;
        if (stall_cycles !== 32'd0 || tiles_swapped !== 32'd0) begin
            n_bad++;
            $display("FAIL arst_stats got %0d %0d want 0 0",
                     stall_cycles, tiles_swapped);
        end
`endif
        @(negedge clk);
        resetn = 1;
        for (int i = 0; i < SZI; i++) begin
            fresh[i] = 64'hF0 + 64'(i * 3);
            want[i*PW +: PW] = fresh[i];
            p_valid = 1;
            p_word = fresh[i];
            cyc();
        end
        idle_inputs();
        d_valid = 1;
        d_new_tile_k = 1;
        d_last_tile_k = 1;
        cyc();
        idle_inputs();
        #1;
        n_cmp++;
        if (active_vec !== want || swap !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_reload got s%b %h want s1 %h",
                     swap, active_vec, want);
        end
`ifdef QPARAM_SCHED_STATS_EN
        n_cmp++;
        if (stall_cycles !== 32'd0 || tiles_swapped !== 32'd1) begin
            n_bad++;
            $display("FAIL arst_stats2 got %0d %0d want 0 1",
                     stall_cycles, tiles_swapped);
        end
`endif
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_swap();
        test_partial();
        test_stall();
        test_simul();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
